// File: rtl/halt_ctrl.sv
// Halt controller: snoops core stores to the tohost word, drains, then freezes the core and reports pass/fail.
// Optional watchdog timeout is compiled in when HALT_WDOG_EN is defined.
module halt_ctrl #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          CNT_W        = 32,
    parameter int          TIMEOUT      = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_wen,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             halt,
    output logic             done,
    output logic             pass,
    output logic [30:0]      exit_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam int          DW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [29:0] TOHOST_WORD = TOHOST_ADDR[31:2];

    logic [1:0]       state_r;
    logic [DW-1:0]    drain_cnt_r;
    logic [CNT_W-1:0] cycle_count_r;
    logic [30:0]      exit_code_r;
    logic             pass_next_r;
    logic             halt_r;
    logic             done_r;
    logic             pass_r;

    logic             exit_hit_s;
    logic             wdog_hit_s;
    logic             unused_addr_s;

    // Byte-lane bits of the address do not select a different word.
    assign unused_addr_s = ^mem_addr[1:0];

    assign exit_hit_s = mem_wen && (mem_addr[31:2] == TOHOST_WORD) && mem_wdata[0];

`ifdef HALT_WDOG_EN
    assign wdog_hit_s = (cycle_count_r == CNT_W'(TIMEOUT - 1));
`else
    // Without the watchdog this comparison is constant false.
    assign wdog_hit_s = (TIMEOUT < 0);
`endif

    // Main FSM: count run cycles, capture the first exit, drain, then hold halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            drain_cnt_r   <= '0;
            cycle_count_r <= '0;
            exit_code_r   <= 31'd0;
            pass_next_r   <= 1'b0;
            halt_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (exit_hit_s) begin
                        exit_code_r <= mem_wdata[31:1];
                        pass_next_r <= (mem_wdata[31:1] == 31'd0);
                        drain_cnt_r <= '0;
                        state_r     <= ST_DRAIN;
                    end else if (wdog_hit_s) begin
                        exit_code_r <= 31'h7FFF_FFFF;
                        pass_next_r <= 1'b0;
                        drain_cnt_r <= '0;
                        state_r     <= ST_DRAIN;
                    end else begin
                        cycle_count_r <= cycle_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_r <= ST_HALTED;
                        halt_r  <= 1'b1;
                        done_r  <= 1'b1;
                        pass_r  <= pass_next_r;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + {{(DW-1){1'b0}}, 1'b1};
                    end
                end
                ST_HALTED: begin
                    halt_r <= 1'b1;
                    pass_r <= pass_next_r;
                end
                default: begin
                    // An illegal encoding drops the core back to a clean run state.
                    state_r <= ST_RUN;
                    halt_r  <= 1'b0;
                    pass_r  <= 1'b0;
                end
            endcase
        end
    end

    assign halt        = halt_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign exit_code   = exit_code_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed, table-driven bench for halt_ctrl (watchdog sequences only when HALT_WDOG_EN is defined).
module tb_halt_ctrl;

`ifdef HALT_WDOG_EN
    localparam int TO = 50;
`else
    localparam int TO = 10000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        halt;
    logic        done;
    logic        pass;
    logic [30:0] exit_code;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        halt;
        logic        done;
        logic        pass;
        logic [30:0] exit;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[10];

    halt_ctrl #(
        .TOHOST_ADDR (32'h0000_1000),
        .DRAIN_CYCLES(4),
        .CNT_W       (32),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .halt       (halt),
        .done       (done),
        .pass       (pass),
        .exit_code  (exit_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic h, input logic dn, input logic p,
                              input logic [30:0] ex, input logic [31:0] cnt);
        check({tag, ".halt"},  {31'd0, halt}, {31'd0, h});
        check({tag, ".done"},  {31'd0, done}, {31'd0, dn});
        check({tag, ".pass"},  {31'd0, pass}, {31'd0, p});
        check({tag, ".exit"},  {1'b0, exit_code}, {1'b0, ex});
        check({tag, ".cnt"},   cycle_count, cnt);
    endtask

    task automatic step(input logic wen, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst = 1'b0; mem_wen = wen; mem_addr = a; mem_wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; mem_wen = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_wen = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;

        // Test 1: clean pass after 20 run cycles.
        do_reset(3);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 32'd0);
        step(1'b1, 32'h1000, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0);
            check_outs("t1_drain", 1'b0, 1'b0, 1'b0, 31'd0, 32'd20);
        end
        step(1'b0, 32'd0, 32'd0);
        check_outs("t1_halt", 1'b1, 1'b1, 1'b1, 31'd0, 32'd20);
        step(1'b0, 32'd0, 32'd0);
        check_outs("t1_hold", 1'b1, 1'b0, 1'b1, 31'd0, 32'd20);

        // Test 5: reset while halted returns to RUN on the next edge.
        do_reset(1);
        check_outs("t5_rst", 1'b0, 1'b0, 1'b0, 31'd0, 32'd0);
        step(1'b0, 32'd0, 32'd0);
        check_outs("t5_run", 1'b0, 1'b0, 1'b0, 31'd0, 32'd1);

        // Tests 2/3/4: ignored stores, failing exit, store during drain, store after halt.
        tbl[0] = '{1'b1, 32'h1000, 32'h6, 1'b0, 1'b0, 1'b0, 31'd0, 32'd1};
        tbl[1] = '{1'b1, 32'h1004, 32'h1, 1'b0, 1'b0, 1'b0, 31'd0, 32'd2};
        tbl[2] = '{1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 31'd0, 32'd3};
        tbl[3] = '{1'b1, 32'h1000, 32'h7, 1'b0, 1'b0, 1'b0, 31'd3, 32'd3};
        tbl[4] = '{1'b1, 32'h1000, 32'h5, 1'b0, 1'b0, 1'b0, 31'd3, 32'd3};
        tbl[5] = '{1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 31'd3, 32'd3};
        tbl[6] = '{1'b0, 32'h0,    32'h0, 1'b0, 1'b0, 1'b0, 31'd3, 32'd3};
        tbl[7] = '{1'b0, 32'h0,    32'h0, 1'b1, 1'b1, 1'b0, 31'd3, 32'd3};
        tbl[8] = '{1'b0, 32'h0,    32'h0, 1'b1, 1'b0, 1'b0, 31'd3, 32'd3};
        tbl[9] = '{1'b1, 32'h1000, 32'h1, 1'b1, 1'b0, 1'b0, 31'd3, 32'd3};
        do_reset(3);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].wen, tbl[i].addr, tbl[i].wdata);
            check_outs($sformatf("tbl%0d", i), tbl[i].halt, tbl[i].done, tbl[i].pass,
                       tbl[i].exit, tbl[i].cnt);
        end

`ifdef HALT_WDOG_EN
        // Test 6a: watchdog expiry with no stores.
        do_reset(3);
        for (int i = 0; i < 50; i++) step(1'b0, 32'd0, 32'd0);
        check_outs("t6_to", 1'b0, 1'b0, 1'b0, 31'h7FFF_FFFF, 32'd49);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0);
        check_outs("t6_pre", 1'b0, 1'b0, 1'b0, 31'h7FFF_FFFF, 32'd49);
        step(1'b0, 32'd0, 32'd0);
        check_outs("t6_halt", 1'b1, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd49);

        // Test 6b: exit on the expiry cycle wins over the watchdog.
        do_reset(3);
        for (int i = 0; i < 49; i++) step(1'b0, 32'd0, 32'd0);
        step(1'b1, 32'h1000, 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0);
        check_outs("t6_exit", 1'b1, 1'b1, 1'b1, 31'd0, 32'd49);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
